// File: rtl/pos_embed_add_if.sv
// rtl/pos_embed_add_if.sv - frame capture and token stream bundle for pos_embed_add
interface pos_embed_add_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_PATCHES = 4,
  parameter int E           = 8
);
  localparam int NUM_TOK = NUM_PATCHES + 1;
  localparam int TOK_W   = (NUM_TOK > 1) ? $clog2(NUM_TOK) : 1;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [DATA_WIDTH*NUM_PATCHES*E-1:0]   patch_in;
  logic [DATA_WIDTH*NUM_TOK*E-1:0]       pos_in;
  logic [DATA_WIDTH*E-1:0]               cls_in;
  logic                                  tok_valid;
  logic                                  tok_ready;
  logic [DATA_WIDTH*E-1:0]               tok_data;
  logic [TOK_W-1:0]                      tok_idx;
  logic                                  tok_last;
  logic                                  done;

  modport slave (
    input  in_valid, patch_in, pos_in, cls_in, tok_ready,
    output in_ready, tok_valid, tok_data, tok_idx, tok_last, done
  );

  modport master (
    output in_valid, patch_in, pos_in, cls_in, tok_ready,
    input  in_ready, tok_valid, tok_data, tok_idx, tok_last, done
  );
endinterface

// File: rtl/pos_embed_add.sv
// rtl/pos_embed_add.sv - prepends class token, adds positional embedding with
// unsigned saturation, and streams NUM_PATCHES+1 tokens one per handshake.
module pos_embed_add #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_PATCHES = 4,
  parameter int E           = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pos_embed_add_if.slave bus
);
  localparam int NUM_TOK = NUM_PATCHES + 1;
  localparam int TOK_W   = (NUM_TOK > 1) ? $clog2(NUM_TOK) : 1;
  localparam int EIDX_W  = (E > 1) ? $clog2(E) : 1;
  localparam int PATCH_W = DATA_WIDTH * NUM_PATCHES * E;
  localparam int POS_W   = DATA_WIDTH * NUM_TOK * E;
  localparam int VEC_W   = DATA_WIDTH * E;

  localparam logic [TOK_W-1:0]  LAST_T = TOK_W'(NUM_TOK - 1);
  localparam logic [EIDX_W-1:0] LAST_E = EIDX_W'(E - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TOK_W-1:0]    tok_cnt_q, tok_cnt_d;
  logic [EIDX_W-1:0]   elem_idx_q, elem_idx_d;
  logic [PATCH_W-1:0]  patch_buf_q, patch_buf_d;
  logic [POS_W-1:0]    pos_buf_q, pos_buf_d;
  logic [VEC_W-1:0]    cls_buf_q, cls_buf_d;
  logic [VEC_W-1:0]    out_buf_q, out_buf_d;

  int                  tok_i;
  int                  elem_i;
  logic [DATA_WIDTH-1:0] src_elem;
  logic [DATA_WIDTH-1:0] pos_elem;
  logic [DATA_WIDTH:0]   sum_full;
  logic [DATA_WIDTH-1:0] sum_sat;

  // Token 0 draws from the class token; token t>=1 draws from patch t-1.
  always_comb begin
    tok_i  = int'(tok_cnt_q);
    elem_i = int'(elem_idx_q);
    if (tok_i == 0) begin
      src_elem = cls_buf_q[elem_i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      src_elem = patch_buf_q[((tok_i - 1) * E + elem_i) * DATA_WIDTH +: DATA_WIDTH];
    end
    pos_elem = pos_buf_q[(tok_i * E + elem_i) * DATA_WIDTH +: DATA_WIDTH];
    sum_full = {1'b0, src_elem} + {1'b0, pos_elem};
    sum_sat  = sum_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_full[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    tok_cnt_d   = tok_cnt_q;
    elem_idx_d  = elem_idx_q;
    patch_buf_d = patch_buf_q;
    pos_buf_d   = pos_buf_q;
    cls_buf_d   = cls_buf_q;
    out_buf_d   = out_buf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          patch_buf_d = bus.patch_in;
          pos_buf_d   = bus.pos_in;
          cls_buf_d   = bus.cls_in;
          tok_cnt_d   = '0;
          elem_idx_d  = '0;
          state_d     = S_ADD;
        end
      end
      S_ADD: begin
        out_buf_d[elem_i*DATA_WIDTH +: DATA_WIDTH] = sum_sat;
        if (elem_idx_q == LAST_E) begin
          state_d = S_SEND;
        end else begin
          elem_idx_d = elem_idx_q + EIDX_W'(1);
        end
      end
      S_SEND: begin
        if (bus.tok_ready) begin
          if (tok_cnt_q == LAST_T) begin
            state_d = S_DONE;
          end else begin
            tok_cnt_d  = tok_cnt_q + TOK_W'(1);
            elem_idx_d = '0;
            state_d    = S_ADD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tok_cnt_q   <= '0;
      elem_idx_q  <= '0;
      patch_buf_q <= '0;
      pos_buf_q   <= '0;
      cls_buf_q   <= '0;
      out_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      tok_cnt_q   <= tok_cnt_d;
      elem_idx_q  <= elem_idx_d;
      patch_buf_q <= patch_buf_d;
      pos_buf_q   <= pos_buf_d;
      cls_buf_q   <= cls_buf_d;
      out_buf_q   <= out_buf_d;
    end
  end

  // Every output is a decode of registered state; tok_ready never reaches an output.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.tok_valid = (state_q == S_SEND);
  assign bus.tok_data  = out_buf_q;
  assign bus.tok_idx   = tok_cnt_q;
  assign bus.tok_last  = (state_q == S_SEND) && (tok_cnt_q == LAST_T);
  assign bus.done      = (state_q == S_DONE);

  a_hold_under_stall: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.tok_valid && !bus.tok_ready |=>
      bus.tok_valid && $stable(bus.tok_data) && $stable(bus.tok_idx)
  );

  a_elem_in_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    int'(elem_idx_q) < E
  );
endmodule

// File: tb/tb_pos_embed_add.sv
// tb/tb_pos_embed_add.sv - randomized frames with backpressure, isolation,
// mid-stream reset and back-to-back capture against a table-driven model.
module tb_pos_embed_add;
  localparam int DW   = 4;
  localparam int NP   = 4;
  localparam int E    = 8;
  localparam int NT   = NP + 1;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pos_embed_add_if #(.DATA_WIDTH(DW), .NUM_PATCHES(NP), .E(E)) bus ();

  pos_embed_add #(.DATA_WIDTH(DW), .NUM_PATCHES(NP), .E(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  int cls_a   [E];
  int patch_a [NP][E];
  int pos_a   [NT][E];
  int stall_a [NT];
  logic [DW*E-1:0] exp_tok [NT];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build_expected();
    int s, v;
    for (int t = 0; t < NT; t++) begin
      for (int e = 0; e < E; e++) begin
        s = (t == 0) ? cls_a[e] : patch_a[t-1][e];
        v = s + pos_a[t][e];
        if (v > MAXV) v = MAXV;
        exp_tok[t][e*DW +: DW] = DW'(v);
      end
    end
  endfunction

  task automatic drive_inputs();
    for (int e = 0; e < E; e++) bus.cls_in[e*DW +: DW] = DW'(cls_a[e]);
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < E; e++) bus.patch_in[(p*E+e)*DW +: DW] = DW'(patch_a[p][e]);
    for (int t = 0; t < NT; t++)
      for (int e = 0; e < E; e++) bus.pos_in[(t*E+e)*DW +: DW] = DW'(pos_a[t][e]);
  endtask

  task automatic scramble_inputs();
    for (int e = 0; e < E; e++) bus.cls_in[e*DW +: DW] = DW'($urandom);
    for (int k = 0; k < NP*E; k++) bus.patch_in[k*DW +: DW] = DW'($urandom);
    for (int k = 0; k < NT*E; k++) bus.pos_in[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic set_basic();
    for (int e = 0; e < E; e++) cls_a[e] = MAXV;
    for (int p = 0; p < NP; p++) for (int e = 0; e < E; e++) patch_a[p][e] = p + 1;
    for (int t = 0; t < NT; t++) for (int e = 0; e < E; e++) pos_a[t][e] = e;
  endtask

  task automatic set_random();
    for (int e = 0; e < E; e++) cls_a[e] = $urandom_range(0, MAXV);
    for (int p = 0; p < NP; p++) for (int e = 0; e < E; e++) patch_a[p][e] = $urandom_range(0, MAXV);
    for (int t = 0; t < NT; t++) for (int e = 0; e < E; e++) pos_a[t][e] = $urandom_range(0, MAXV);
  endtask

  task automatic clear_stalls();
    for (int t = 0; t < NT; t++) stall_a[t] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tok_valid"}, 64'(bus.tok_valid), 64'(0));
    check_eq({tag, "_tok_data"},  64'(bus.tok_data),  64'(0));
    check_eq({tag, "_tok_idx"},   64'(bus.tok_idx),   64'(0));
    check_eq({tag, "_tok_last"},  64'(bus.tok_last),  64'(0));
    check_eq({tag, "_done"},      64'(bus.done),      64'(0));
    check_eq({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
  endtask

  task automatic idle_check();
    @(negedge clk);
    check_eq("in_ready_stays_idle", 64'(bus.in_ready), 64'(1));
  endtask

  // Called at a negedge of an idle cycle; the capture edge is the next posedge.
  task automatic run_frame(input bit poke, input bit keep_valid, input int abort_after,
                           input bit chk_tok2);
    int t, nxt, last_acc, stall_total;
    bit seen_done, exp_v, exp_d;
    build_expected();
    drive_inputs();
    bus.in_valid = 1'b1;
    check_eq("in_ready_capture", 64'(bus.in_ready), 64'(1));
    stall_total = 0;
    for (int k = 0; k < NT; k++) stall_total += stall_a[k];
    @(posedge clk);
    t = 0; nxt = E + 1; last_acc = 0; seen_done = 1'b0;
    for (int c = 1; c <= 400 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 1 && !keep_valid) bus.in_valid = 1'b0;
      if (abort_after > 0 && t == 2 && c == last_acc + abort_after) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        bus.in_valid  = 1'b0;
        bus.tok_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
        return;
      end
      if (poke && c >= 12) begin
        bus.in_valid = 1'b1;
        scramble_inputs();
      end
      exp_v = (t < NT) && (c >= nxt);
      check_eq("in_ready_busy", 64'(bus.in_ready), 64'(0));
      check_eq("tok_valid", 64'(bus.tok_valid), 64'(exp_v));
      check_eq("tok_last", 64'(bus.tok_last), 64'(exp_v && (t == NT - 1)));
      if (exp_v) begin
        check_eq("tok_idx", 64'(bus.tok_idx), 64'(t));
        check_eq("tok_data", 64'(bus.tok_data), 64'(exp_tok[t]));
        if (chk_tok2 && t == 2) check_eq("tok2_literal", 64'(bus.tok_data), 64'h98765432);
      end
      exp_d = (t == NT) && (c == last_acc + 1);
      check_eq("done", 64'(bus.done), 64'(exp_d));
      if (exp_d) begin
        check_eq("done_cycle", 64'(c), 64'(NT * (E + 1) + 1 + stall_total));
        seen_done = 1'b1;
        if (!keep_valid) bus.in_valid = 1'b0;
      end
      if (exp_v && stall_a[t] > 0) begin
        bus.tok_ready = 1'b0;
        stall_a[t]--;
      end else begin
        bus.tok_ready = 1'b1;
        if (exp_v) begin
          last_acc = c;
          t++;
          nxt = c + E + 1;
        end
      end
    end
    if (!seen_done) check_eq("frame_timeout", 64'(0), 64'(1));
    @(negedge clk);
    check_eq("in_ready_after_done", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.tok_ready = 1'b1;
    bus.patch_in  = '0;
    bus.pos_in    = '0;
    bus.cls_in    = '0;
    clear_stalls();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_post_reset", 64'(bus.in_ready), 64'(1));

    set_basic(); clear_stalls();
    run_frame(1'b0, 1'b0, 0, 1'b1);
    idle_check();

    set_random(); clear_stalls();
    for (int e = 0; e < E; e++) begin
      if (e < 3)      begin patch_a[0][e] = 9; pos_a[1][e] = 8; end
      else if (e < 6) begin patch_a[0][e] = 7; pos_a[1][e] = 8; end
      else            begin patch_a[0][e] = 0; pos_a[1][e] = 0; end
    end
    run_frame(1'b0, 1'b0, 0, 1'b0);
    idle_check();

    set_basic(); clear_stalls();
    stall_a[1] = 3;
    run_frame(1'b0, 1'b0, 0, 1'b1);
    idle_check();

    set_random(); clear_stalls();
    run_frame(1'b1, 1'b0, 0, 1'b0);
    idle_check();

    set_random(); clear_stalls();
    run_frame(1'b0, 1'b0, 3, 1'b0);
    set_random(); clear_stalls();
    run_frame(1'b0, 1'b0, 0, 1'b0);
    idle_check();

    set_random(); clear_stalls();
    run_frame(1'b0, 1'b1, 0, 1'b0);
    set_random(); clear_stalls();
    run_frame(1'b0, 1'b0, 0, 1'b0);
    idle_check();

    for (int f = 0; f < 6; f++) begin
      set_random();
      for (int t = 0; t < NT; t++) stall_a[t] = $urandom_range(0, 2);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
